// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALUOp, R-type funct codes, FSM states.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_NOP   = 2'b11;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial product per clock.
// done/product are combinational and describe the step taken on the coming
// edge, so the caller can register the final product on the completing edge.
module mul_iter
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(MUL_STEPS + 1);

    logic            busy_q,   busy_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0] mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] step_acc;

    // Accumulate one partial product; load operands on start
    always_comb begin
        step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
        end else if (busy_q) begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(MUL_STEPS - 1)) busy_d = 1'b0;
        end
    end

    assign done    = busy_q && (cnt_q == CW'(MUL_STEPS - 1));
    assign product = step_acc;

    // Multiplier state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage with EX/WB register. Single-cycle ALU ops plus a
// multi-cycle MUL that stalls ID/EX while the iterative multiplier runs.
module ex_stage
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWrite_in,
    input  logic [1:0]      ALUOp_in,
    input  logic [5:0]      funct_in,
    input  logic [4:0]      shamt_in,
    input  logic [4:0]      RdAddr_in,
    input  logic [XLEN-1:0] RsData_in,
    input  logic [XLEN-1:0] RtData_in,
    output logic            stall_out,
    output logic            RegWrite_out,
    output logic [4:0]      RdAddr_out,
    output logic [XLEN-1:0] Result_out
);
    logic [0:0]      state_q,    state_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      rd_q,       rd_d;
    logic [XLEN-1:0] result_q,   result_d;
    logic [4:0]      mul_rd_q,   mul_rd_d;

    logic [XLEN-1:0] alu_res;
    logic            alu_ok;
    logic            mul_issue;
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;

    // Combinational ALU; alu_ok low marks a bubble or unsupported funct
    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b0;
        case (ALUOp_in)
            ALUOP_ADD: begin alu_res = RsData_in + RtData_in; alu_ok = 1'b1; end
            ALUOP_SUB: begin alu_res = RsData_in - RtData_in; alu_ok = 1'b1; end
            ALUOP_RTYPE: begin
                alu_ok = 1'b1;
                case (funct_in)
                    FN_ADD:  alu_res = RsData_in + RtData_in;
                    FN_SUB:  alu_res = RsData_in - RtData_in;
                    FN_AND:  alu_res = RsData_in & RtData_in;
                    FN_OR:   alu_res = RsData_in | RtData_in;
                    FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(RsData_in) < $signed(RtData_in)};
                    FN_SLL:  alu_res = RtData_in << shamt_in;
                    FN_SRL:  alu_res = RtData_in >> shamt_in;
                    default: alu_ok  = 1'b0;  // includes MUL: never a 1-cycle op
                endcase
            end
            default: alu_ok = 1'b0;
        endcase
    end

    assign mul_issue = (state_q == ST_IDLE) && (ALUOp_in == ALUOP_RTYPE) &&
                       (funct_in == FN_MUL) && RegWrite_in;

    mul_iter #(.XLEN(XLEN), .MUL_STEPS(MUL_STEPS)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_issue),
        .a       (RsData_in),
        .b       (RtData_in),
        .done    (mul_done),
        .product (mul_prod)
    );

    // FSM and EX/WB next values; outputs default to a bubble
    always_comb begin
        state_d    = state_q;
        regwrite_d = 1'b0;
        result_d   = '0;
        rd_d       = rd_q;
        mul_rd_d   = mul_rd_q;
        case (state_q)
            ST_IDLE: begin
                rd_d = RdAddr_in;
                if (mul_issue) begin
                    state_d  = ST_MUL;
                    mul_rd_d = RdAddr_in;
                end else begin
                    regwrite_d = RegWrite_in & alu_ok;
                    result_d   = alu_ok ? alu_res : '0;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d    = ST_IDLE;
                    regwrite_d = 1'b1;
                    rd_d       = mul_rd_q;
                    result_d   = mul_prod;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and EX/WB pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            mul_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            mul_rd_q   <= mul_rd_d;
        end
    end

    assign stall_out    = (state_q == ST_MUL);
    assign RegWrite_out = regwrite_q;
    assign RdAddr_out   = rd_q;
    assign Result_out   = result_q;

endmodule
